cpu_step_ctrl: RTL and testbench
================================

# cpu_step_ctrl

Clock-enable generator for the soft 6502 that replaces the ad-hoc manual/auto clock mux and edge pulser. It debounces the two board keys itself, and produces a single-`clk`-wide `cpu_ce` strobe in three modes: manual single-step, free-run at a programmable rate, or N-step burst. It also provides a step counter and an optional address breakpoint. It sits between the keys and the CPU/memory, which all run on `clk` and advance only when `cpu_ce` is high.

## Interface
Parameters:
- `DIV_WIDTH`, 18: width of the run-rate divider.
- `BURST_WIDTH`, 8: width of the burst length.
- `DEBOUNCE_CYCLES`, 50000: cycles a key level must stay stable before it is accepted (≥1).

Ports:
- `clk` in 1: system clock; the only clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `key_step_n` in 1: raw step key, active-low, asynchronous to `clk`.
- `key_mode_n` in 1: raw mode key, active-low, asynchronous to `clk`.
- `div_value` in DIV_WIDTH: run-rate divisor; strobe period is `div_value+1` cycles.
- `burst_len` in BURST_WIDTH: number of strobes per burst.
- `addr` in 16: CPU address bus, used only for the breakpoint.
- `bp_addr` in 16: breakpoint address.
- `bp_valid` in 1: breakpoint armed.
- `cpu_ce` out 1: CPU/memory clock enable, one-cycle strobe.
- `mode` out 2: current mode; 0 = MANUAL, 1 = RUN, 2 = BURST.
- `busy` out 1: high while a burst is issuing strobes.
- `step_count` out 16: count of `cpu_ce` strobes; wraps from 0xFFFF to 0.
- `bp_hit` out 1: sticky flag, set when the breakpoint stopped execution.

## Operation
- Each key passes through a 2-flop synchroniser, then a debounce counter. The counter reloads on any level change. The level is accepted when it has stayed stable for DEBOUNCE_CYCLES cycles. A press event is a 1-cycle pulse on the accepted high→low transition. Releases generate no event.
- Mode event: the mode cycles MANUAL→RUN→BURST→MANUAL. It also clears the divider, `busy`, the remaining-burst count and `bp_hit`.
- MANUAL: each step event produces exactly one `cpu_ce`. The divider is idle.
- RUN: a divider counts 0..`div_value`. `cpu_ce` is asserted on the cycle the divider equals `div_value`, and the divider then returns to 0. With `div_value`=0, `cpu_ce` is asserted every cycle. Step events are ignored.
- BURST:
  - A step event while `busy`=0 loads `remaining`←`burst_len`, sets `busy` and clears the divider.
  - Strobes are then issued at the RUN rate. `remaining` decrements on each strobe.
  - `busy` clears on the cycle of the last strobe.
  - `burst_len`=0 produces no strobe, and `busy` stays 0.
  - A step event while `busy`=1 is ignored.
- `div_value` and `burst_len` are sampled live, except that `burst_len` is captured only at the burst start.
- `step_count` increments on every `cpu_ce` cycle, in all modes.
- Simultaneous mode and step events on the same cycle: the mode event wins and the step event is dropped.

## Timing
- Reset values: `cpu_ce`=0, `mode`=0 (MANUAL), `busy`=0, `step_count`=0, `bp_hit`=0. Divider, `remaining` and debounce counters are all 0. Debounced key levels are 1 (released).
- Key-to-event latency: 2 synchroniser cycles + DEBOUNCE_CYCLES cycles after the last bounce.
- MANUAL: `cpu_ce` is high on the cycle after the step event.
- BURST: the first strobe comes `div_value+1` cycles after the step event. Strobes then repeat every `div_value+1` cycles.
- `cpu_ce` and `mode` are registered outputs.
- Reset asserted mid-burst aborts immediately. All outputs return to their reset values asynchronously.

## Configuration
- Macro `CPU_STEP_CTRL_BREAKPOINT_EN`.
- Defined:
  - On the cycle after any `cpu_ce` in RUN or BURST, if `bp_valid`=1 and `addr`==`bp_addr`, the block forces `mode`←MANUAL, clears `busy`/`remaining` and sets `bp_hit`.
  - No further strobes are issued until a step event.
  - `bp_hit` clears on the next mode event.
  - Breakpoints never fire in MANUAL.
- Undefined: `addr`, `bp_addr` and `bp_valid` are ignored, and `bp_hit` is tied to 0.

## Test plan
Bench uses DEBOUNCE_CYCLES=4.
- Reset release, no key activity for 100 cycles → `cpu_ce` never high, `mode`=0, `step_count`=0.
- `key_step_n` bounces (3 toggles at 1-cycle spacing), then is held low for 10 cycles → exactly one `cpu_ce` and `step_count`=1. Release, then a second clean press → `step_count`=2.
- One mode press → `mode`=1. With `div_value`=3, run 40 cycles → `cpu_ce` every 4th cycle, 10 strobes total, `step_count`=10. Then `div_value`=0 → `cpu_ce` held continuously high.
- Two mode presses → `mode`=2. `burst_len`=5, `div_value`=1, then a step press → 5 strobes 2 cycles apart and `busy` low after the 5th. A second step press while busy → ignored. `burst_len`=0 plus a step press → no strobe.
- Mode and step events forced onto the same cycle → mode advances and no strobe occurs. `rst_n` pulsed low mid-burst → `cpu_ce`=0, `busy`=0, `mode`=0 immediately.
- With `CPU_STEP_CTRL_BREAKPOINT_EN`: RUN mode, `bp_addr`=0x8004, `bp_valid`=1, `addr` incrementing from 0x8000 per strobe → stops after the strobe that produced 0x8004 with `mode`=0 and `bp_hit`=1. A mode press then clears `bp_hit`. Without the macro → running continues and `bp_hit` stays 0.

Source files
------------

// File: rtl/cpu_step_ctrl.sv
// cpu_step_ctrl: debounced single-step / free-run / burst clock-enable generator for the soft 6502.
// Define CPU_STEP_CTRL_BREAKPOINT_EN to enable the address breakpoint (bp_hit is tied low otherwise).
module cpu_step_ctrl #(
    parameter int DIV_WIDTH       = 18,
    parameter int BURST_WIDTH     = 8,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   key_step_n,
    input  logic                   key_mode_n,
    input  logic [DIV_WIDTH-1:0]   div_value,
    input  logic [BURST_WIDTH-1:0] burst_len,
    input  logic [15:0]            addr,
    input  logic [15:0]            bp_addr,
    input  logic                   bp_valid,
    output logic                   cpu_ce,
    output logic [1:0]             mode,
    output logic                   busy,
    output logic [15:0]            step_count,
    output logic                   bp_hit
);
    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        MANUAL = 2'd0,
        RUN    = 2'd1,
        BURST  = 2'd2
    } mode_e;

    // Key conditioning: index 0 = step key, index 1 = mode key.
    logic [1:0]      keys_raw;
    logic [1:0]      sync1_q, sync2_q, cand_q, level_q, press_q;
    logic [DB_W-1:0] db_cnt_q [2];
    logic            step_ev, mode_ev;

    assign keys_raw = {key_mode_n, key_step_n};
    assign step_ev  = press_q[0];
    assign mode_ev  = press_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
            cand_q  <= '1;
            level_q <= '1;
            press_q <= '0;
            for (int k = 0; k < 2; k++) db_cnt_q[k] <= '0;
        end else begin
            sync1_q <= keys_raw;
            sync2_q <= sync1_q;
            for (int k = 0; k < 2; k++) begin
                press_q[k] <= 1'b0;
                if (sync2_q[k] != cand_q[k]) begin
                    cand_q[k]   <= sync2_q[k];
                    db_cnt_q[k] <= '0;
                end else if (cand_q[k] != level_q[k]) begin
                    if (db_cnt_q[k] == DB_LAST) begin
                        level_q[k]  <= cand_q[k];
                        press_q[k]  <= ~cand_q[k];
                        db_cnt_q[k] <= '0;
                    end else begin
                        db_cnt_q[k] <= db_cnt_q[k] + 1'b1;
                    end
                end
            end
        end
    end

    mode_e                  mode_q, mode_d;
    logic [DIV_WIDTH-1:0]   div_q, div_d, div_step;
    logic [BURST_WIDTH-1:0] rem_q, rem_d, rem_now;
    logic                   busy_q, busy_d;
    logic                   ce_q, ce_d;
    logic                   bp_hit_q, bp_hit_d;
    logic [15:0]            cnt_q, cnt_d;
    logic                   bp_fire;

`ifdef CPU_STEP_CTRL_BREAKPOINT_EN
    // addr reflects a strobe only one cycle later, so the compare uses the delayed strobe.
    logic ce_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ce_prev_q <= 1'b0;
        else        ce_prev_q <= ce_q;
    end

    assign bp_fire = ce_prev_q && (mode_q != MANUAL) && bp_valid && (addr == bp_addr);
`else
    logic unused_bp;
    assign unused_bp = ^{addr, bp_addr, bp_valid};
    assign bp_fire   = 1'b0;
`endif

    // >= keeps the divider bounded if div_value is lowered below the current count.
    assign div_step = (div_q >= div_value) ? '0 : div_q + 1'b1;

    always_comb begin
        mode_d   = mode_q;
        div_d    = div_q;
        rem_d    = rem_q;
        busy_d   = busy_q;
        bp_hit_d = bp_hit_q;
        ce_d     = 1'b0;
        rem_now  = '0;
        if (mode_ev) begin
            div_d    = '0;
            rem_d    = '0;
            busy_d   = 1'b0;
            bp_hit_d = 1'b0;
            case (mode_q)
                MANUAL:  mode_d = RUN;
                RUN:     mode_d = BURST;
                default: mode_d = MANUAL;
            endcase
            ce_d = (mode_d == RUN) && (div_value == '0);
        end else if (bp_fire) begin
            mode_d   = MANUAL;
            div_d    = '0;
            rem_d    = '0;
            busy_d   = 1'b0;
            bp_hit_d = 1'b1;
        end else begin
            case (mode_q)
                RUN: begin
                    div_d = div_step;
                    ce_d  = (div_step == div_value);
                end
                BURST: begin
                    if (busy_q || step_ev) begin
                        rem_now = busy_q ? rem_q : burst_len;
                        div_d   = busy_q ? div_step : '0;
                        ce_d    = (div_d == div_value) && (rem_now != '0);
                        rem_d   = rem_now - BURST_WIDTH'(ce_d);
                        busy_d  = (rem_d != '0);
                    end
                end
                default: begin
                    div_d = '0;
                    ce_d  = step_ev;
                end
            endcase
        end
        cnt_d = cnt_q + 16'(ce_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= MANUAL;
            div_q    <= '0;
            rem_q    <= '0;
            busy_q   <= 1'b0;
            ce_q     <= 1'b0;
            bp_hit_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            mode_q   <= mode_d;
            div_q    <= div_d;
            rem_q    <= rem_d;
            busy_q   <= busy_d;
            ce_q     <= ce_d;
            bp_hit_q <= bp_hit_d;
            cnt_q    <= cnt_d;
        end
    end

    assign cpu_ce     = ce_q;
    assign mode       = mode_q;
    assign busy       = busy_q;
    assign step_count = cnt_q;
    assign bp_hit     = bp_hit_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Self-checking bench for cpu_step_ctrl: directed scenarios plus random key activity,
// every cycle compared against an event-level reference model.
module tb_cpu_step_ctrl;
    localparam int DB = 4;
`ifdef CPU_STEP_CTRL_BREAKPOINT_EN
    localparam bit BP_EN = 1'b1;
`else
    localparam bit BP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        key_step_n = 1'b1;
    logic        key_mode_n = 1'b1;
    logic [17:0] div_value = 18'd3;
    logic [7:0]  burst_len = 8'd5;
    logic [15:0] addr = 16'h0000;
    logic [15:0] bp_addr = 16'h8004;
    logic        bp_valid = 1'b0;
    logic        cpu_ce;
    logic [1:0]  mode;
    logic        busy;
    logic [15:0] step_count;
    logic        bp_hit;

    cpu_step_ctrl #(.DIV_WIDTH(18), .BURST_WIDTH(8), .DEBOUNCE_CYCLES(DB)) dut (
        .clk(clk), .rst_n(rst_n), .key_step_n(key_step_n), .key_mode_n(key_mode_n),
        .div_value(div_value), .burst_len(burst_len), .addr(addr), .bp_addr(bp_addr),
        .bp_valid(bp_valid), .cpu_ce(cpu_ce), .mode(mode), .busy(busy),
        .step_count(step_count), .bp_hit(bp_hit)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: keys are accepted once the synchronised level has been seen on
    // DB+1 consecutive samples; strobes follow mode rules with plain integer bookkeeping.
    int m_mode, m_div, m_rem, m_cnt;
    bit m_busy, m_ce, m_prev_ce, m_bphit;
    bit m_h1 [2];
    bit m_h2 [2];
    bit m_last [2];
    bit m_lvl [2];
    bit m_press [2];
    int m_run [2];

    task automatic model_reset();
        m_mode = 0; m_div = 0; m_rem = 0; m_cnt = 0;
        m_busy = 0; m_ce = 0; m_prev_ce = 0; m_bphit = 0;
        for (int k = 0; k < 2; k++) begin
            m_h1[k] = 1; m_h2[k] = 1; m_last[k] = 1; m_lvl[k] = 1; m_press[k] = 0; m_run[k] = 0;
        end
    endtask

    task automatic model_step();
        bit raw [2];
        bit s, sev, mev, bpf, ce_next;
        int dv;
        raw[0] = key_step_n;
        raw[1] = key_mode_n;
        sev = m_press[0];
        mev = m_press[1];
        dv  = int'(div_value);
        for (int k = 0; k < 2; k++) begin
            s = m_h2[k];
            m_h2[k] = m_h1[k];
            m_h1[k] = raw[k];
            m_run[k] = (s == m_last[k]) ? m_run[k] + 1 : 1;
            m_last[k] = s;
            m_press[k] = 0;
            if (m_run[k] >= DB + 1 && m_lvl[k] != s) begin
                m_lvl[k] = s;
                m_press[k] = !s;
            end
        end
        bpf = BP_EN && m_prev_ce && m_mode != 0 && bp_valid && addr == bp_addr;
        ce_next = 0;
        if (mev) begin
            m_mode = (m_mode + 1) % 3;
            m_div = 0; m_rem = 0; m_busy = 0; m_bphit = 0;
            ce_next = (m_mode == 1) && (dv == 0);
        end else if (bpf) begin
            m_mode = 0; m_div = 0; m_rem = 0; m_busy = 0; m_bphit = 1;
        end else if (m_mode == 1) begin
            m_div = (m_div >= dv) ? 0 : m_div + 1;
            ce_next = (m_div == dv);
        end else if (m_mode == 2) begin
            if (m_busy) begin
                m_div = (m_div >= dv) ? 0 : m_div + 1;
                if (m_div == dv) begin
                    ce_next = 1;
                    m_rem--;
                    m_busy = (m_rem > 0);
                end
            end else if (sev) begin
                m_div = 0;
                m_rem = int'(burst_len);
                if (m_rem > 0 && dv == 0) begin
                    ce_next = 1;
                    m_rem--;
                end
                m_busy = (m_rem > 0);
            end
        end else begin
            m_div = 0;
            ce_next = sev;
        end
        m_prev_ce = m_ce;
        m_ce = ce_next;
        m_cnt = (m_cnt + int'(ce_next)) % 65536;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    // Per-cycle comparison, strobe bookkeeping and a toy CPU that advances addr per strobe.
    int cyc = 0;
    int ce_seen = 0;
    int ce_cyc [$];
    bit ce_busy [$];

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            check("ce", 32'(cpu_ce), 32'(m_ce));
            check("mode", 32'(mode), 32'(m_mode));
            check("busy", 32'(busy), 32'(m_busy));
            check("step_count", 32'(step_count), 32'(m_cnt));
            check("bp_hit", 32'(bp_hit), 32'(m_bphit));
            if (cpu_ce) begin
                ce_seen++;
                ce_cyc.push_back(cyc);
                ce_busy.push_back(busy);
                addr = addr + 16'd1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic press(input bit do_step, input bit do_mode);
        if (do_step) key_step_n = 1'b0;
        if (do_mode) key_mode_n = 1'b0;
        tick(12);
        key_step_n = 1'b1;
        key_mode_n = 1'b1;
        tick(12);
    endtask

    task automatic clear_obs();
        ce_seen = 0;
        ce_cyc.delete();
        ce_busy.delete();
    endtask

    initial begin
        int sc0;
        bit got_busy;
        tick(3);
        check("rst_ce", 32'(cpu_ce), 32'd0);
        check("rst_mode", 32'(mode), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_count", 32'(step_count), 32'd0);
        check("rst_bp_hit", 32'(bp_hit), 32'd0);
        rst_n = 1'b1;

        clear_obs();
        tick(100);
        check("idle_ce", 32'(ce_seen), 32'd0);
        check("idle_mode", 32'(mode), 32'd0);
        check("idle_count", 32'(step_count), 32'd0);

        // Bouncy step press, then a clean one.
        clear_obs();
        key_step_n = 1'b0; tick(1);
        key_step_n = 1'b1; tick(1);
        key_step_n = 1'b0; tick(10);
        key_step_n = 1'b1; tick(15);
        check("bounce_ce", 32'(ce_seen), 32'd1);
        check("bounce_count", 32'(step_count), 32'd1);
        press(1, 0);
        check("step2_count", 32'(step_count), 32'd2);

        // RUN at div 3, then div 0.
        div_value = 18'd3;
        press(0, 1);
        check("run_mode", 32'(mode), 32'd1);
        clear_obs();
        sc0 = int'(step_count);
        tick(40);
        check("run_strobes", 32'(ce_seen), 32'd10);
        check("run_count_delta", 32'((int'(step_count) - sc0 + 65536) % 65536), 32'd10);
        div_value = 18'd0;
        tick(3);
        clear_obs();
        tick(20);
        check("run_div0_strobes", 32'(ce_seen), 32'd20);
        check("run_div0_ce", 32'(cpu_ce), 32'd1);

        // BURST of 5 at div 1.
        div_value = 18'd1;
        burst_len = 8'd5;
        press(0, 1);
        check("burst_mode", 32'(mode), 32'd2);
        clear_obs();
        press(1, 0);
        tick(10);
        check("burst_strobes", 32'(ce_seen), 32'd5);
        for (int i = 1; i < ce_cyc.size(); i++)
            check("burst_gap", 32'(ce_cyc[i] - ce_cyc[i-1]), 32'd2);
        if (ce_busy.size() > 0) begin
            check("busy_first", 32'(ce_busy[0]), 32'd1);
            check("busy_last", 32'(ce_busy[ce_busy.size()-1]), 32'd0);
        end
        check("burst_idle", 32'(busy), 32'd0);

        // Step while busy is ignored.
        div_value = 18'd7;
        clear_obs();
        press(1, 0);
        check("busy_during", 32'(busy), 32'd1);
        press(1, 0);
        tick(60);
        check("busy_ignore", 32'(ce_seen), 32'd5);

        // Zero-length burst.
        burst_len = 8'd0;
        clear_obs();
        press(1, 0);
        tick(10);
        check("zero_burst", 32'(ce_seen), 32'd0);
        check("zero_busy", 32'(busy), 32'd0);

        // Mode and step on the same cycle: mode wins.
        burst_len = 8'd5;
        clear_obs();
        press(1, 1);
        tick(20);
        check("simul_mode", 32'(mode), 32'd0);
        check("simul_ce", 32'(ce_seen), 32'd0);

        // Reset mid-burst.
        press(0, 1);
        press(0, 1);
        check("rstb_mode", 32'(mode), 32'd2);
        burst_len = 8'd20;
        div_value = 18'd2;
        key_step_n = 1'b0;
        got_busy = 1'b0;
        for (int i = 0; i < 40 && !got_busy; i++) begin
            tick(1);
            got_busy = busy;
        end
        check("wait_busy", 32'(got_busy), 32'd1);
        tick(5);
        rst_n = 1'b0;
        #1;
        check("abort_ce", 32'(cpu_ce), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_mode", 32'(mode), 32'd0);
        check("abort_count", 32'(step_count), 32'd0);
        key_step_n = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(20);

        // Breakpoint in RUN.
        div_value = 18'd3;
        bp_valid = 1'b0;
        press(0, 1);
        check("bp_run_mode", 32'(mode), 32'd1);
        addr = 16'h8000;
        bp_addr = 16'h8004;
        bp_valid = 1'b1;
        clear_obs();
        tick(60);
        check("bp_strobes", 32'(ce_seen), BP_EN ? 32'd4 : 32'd15);
        check("bp_addr_end", 32'(addr), BP_EN ? 32'h8004 : 32'h800F);
        check("bp_mode", 32'(mode), BP_EN ? 32'd0 : 32'd1);
        check("bp_hit", 32'(bp_hit), BP_EN ? 32'd1 : 32'd0);
        bp_valid = 1'b0;
        press(0, 1);
        check("bp_clear", 32'(bp_hit), 32'd0);
        check("bp_next_mode", 32'(mode), BP_EN ? 32'd1 : 32'd2);

        // Random key activity with bounce, live settings and breakpoints.
        for (int it = 0; it < 80; it++) begin
            int sel;
            int nb;
            div_value = 18'($urandom_range(0, 4));
            burst_len = 8'($urandom_range(0, 5));
            bp_valid  = 1'($urandom_range(0, 1));
            bp_addr   = addr + 16'($urandom_range(1, 5));
            sel = $urandom_range(0, 3);
            nb  = $urandom_range(0, 3);
            for (int b = 0; b < nb; b++) begin
                if (sel != 2) key_step_n = ~key_step_n;
                if (sel >= 2) key_mode_n = ~key_mode_n;
                tick($urandom_range(1, 2));
            end
            if (sel != 2) key_step_n = 1'b0;
            if (sel >= 2) key_mode_n = 1'b0;
            tick($urandom_range(3, 10));
            key_step_n = 1'b1;
            key_mode_n = 1'b1;
            tick($urandom_range(3, 14));
        end
        tick(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
